// File: rtl/usr.sv
// Universal shift register: STEP-bit logical/arithmetic shifts, load, clear, optional rotate.
// Define USR_ROTATE_EN to build ROL/ROR; otherwise those codes behave as HOLD.
module usr #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [STEP-1:0]                    shift_in,
    input  logic [WIDTH-1:0]                   load_data,
    output logic [WIDTH-1:0]                   shift_out,
    output logic [STEP-1:0]                    eject,
    output logic [$clog2(WIDTH/STEP+1)-1:0]    count,
    output logic                               done
);

    localparam int CW     = $clog2(WIDTH/STEP+1);
    localparam int NSHIFT = WIDTH / STEP;
    localparam logic [CW-1:0] NSHIFT_C = CW'(NSHIFT);

    if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
        $error("usr: illegal WIDTH/STEP combination");
    end

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_SHL   = 3'b001,
        OP_SHR   = 3'b010,
        OP_ASR   = 3'b011,
        OP_LOAD  = 3'b100,
        OP_ROL   = 3'b101,
        OP_ROR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_q, r_d;
    logic [STEP-1:0]  eject_q, eject_d;
    logic [CW-1:0]    count_q, count_d, count_inc;
    logic             done_q, done_d;

    // Saturating increment: shifts after done keep moving data but never wrap the count.
    assign count_inc = (count_q == NSHIFT_C) ? count_q : count_q + CW'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        r_d     = r_q;
        eject_d = eject_q;
        count_d = count_q;
        if (en) begin
            case (op_e'(op))
                OP_SHL: begin
                    r_d     = {r_q[WIDTH-STEP-1:0], shift_in};
                    eject_d = r_q[WIDTH-1 -: STEP];
                    count_d = count_inc;
                end
                OP_SHR: begin
                    r_d     = {shift_in, r_q[WIDTH-1:STEP]};
                    eject_d = r_q[STEP-1:0];
                    count_d = count_inc;
                end
                OP_ASR: begin
                    r_d     = {{STEP{r_q[WIDTH-1]}}, r_q[WIDTH-1:STEP]};
                    eject_d = r_q[STEP-1:0];
                    count_d = count_inc;
                end
                OP_LOAD: begin
                    r_d     = load_data;
                    count_d = '0;
                end
`ifdef USR_ROTATE_EN
                OP_ROL: begin
                    r_d     = {r_q[WIDTH-STEP-1:0], r_q[WIDTH-1 -: STEP]};
                    eject_d = r_q[WIDTH-1 -: STEP];
                    count_d = count_inc;
                end
                OP_ROR: begin
                    r_d     = {r_q[STEP-1:0], r_q[WIDTH-1:STEP]};
                    eject_d = r_q[STEP-1:0];
                    count_d = count_inc;
                end
`endif
                OP_CLEAR: begin
                    r_d     = '0;
                    eject_d = '0;
                    count_d = '0;
                end
                default: ;
            endcase
        end
        done_d = (count_d == NSHIFT_C);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_q     <= '0;
            eject_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            r_q     <= r_d;
            eject_q <= eject_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign shift_out = r_q;
    assign eject     = eject_q;
    assign count     = count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_usr.sv
// Self-checking bench for usr: directed vector table, STEP=2 sequence, random run vs model.
module tb_usr;

`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    localparam int W = 8;
    localparam int S = 1;
    localparam int N = W / S;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: WIDTH=8, STEP=1
    logic       reset = 1'b1, en = 1'b0;
    logic [2:0] op = 3'b000;
    logic [0:0] shift_in = '0;
    logic [7:0] load_data = '0;
    logic [7:0] shift_out;
    logic [0:0] eject;
    logic [3:0] count;
    logic       done;

    usr #(.WIDTH(8), .STEP(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .op(op), .shift_in(shift_in),
        .load_data(load_data), .shift_out(shift_out), .eject(eject),
        .count(count), .done(done)
    );

    // DUT 2: WIDTH=8, STEP=2
    logic       reset2 = 1'b1, en2 = 1'b0;
    logic [2:0] op2 = 3'b000;
    logic [1:0] shift_in2 = '0;
    logic [7:0] load_data2 = '0;
    logic [7:0] shift_out2;
    logic [1:0] eject2;
    logic [2:0] count2;
    logic       done2;

    usr #(.WIDTH(8), .STEP(2)) u2 (
        .clk(clk), .reset(reset2), .en(en2), .op(op2), .shift_in(shift_in2),
        .load_data(load_data2), .shift_out(shift_out2), .eject(eject2),
        .count(count2), .done(done2)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rs;
        logic       e;
        logic [2:0] o;
        logic       si;
        logic [7:0] ld;
        logic [7:0] x_r;
        logic       x_ej;
        int         x_cnt;
        logic       x_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rs, logic e, logic [2:0] o, logic si, logic [7:0] ld,
                                logic [7:0] xr, logic xej, int xc, logic xd);
        vec_t v;
        v.rs = rs; v.e = e; v.o = o; v.si = si; v.ld = ld;
        v.x_r = xr; v.x_ej = xej; v.x_cnt = xc; v.x_done = xd;
        return v;
    endfunction

    task automatic cyc1(input logic rs, input logic e, input logic [2:0] o,
                        input logic si, input logic [7:0] ld);
        reset = rs; en = e; op = o; shift_in = si; load_data = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic rs, input logic e, input logic [2:0] o,
                        input logic [1:0] si, input logic [7:0] ld);
        reset2 = rs; en2 = e; op2 = o; shift_in2 = si; load_data2 = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input string name, input logic [7:0] xr, input logic [1:0] xej,
                          input int xc, input logic xd);
        check({name, ".r"},    32'(shift_out2), 32'(xr));
        check({name, ".ej"},   32'(eject2), 32'(xej));
        check({name, ".cnt"},  32'(count2), 32'(xc));
        check({name, ".done"}, 32'(done2), 32'(xd));
    endtask

    // Behavioural reference for the STEP=1 instance, expressed as integer arithmetic.
    int m_r, m_ej, m_cnt;

    task automatic model_step(input logic rs, input logic e, input logic [2:0] o,
                              input int si, input int ld);
        int wmask, smask;
        bit shifted;
        logic signed [W-1:0] sr;
        wmask = (1 << W) - 1;
        smask = (1 << S) - 1;
        shifted = 1'b0;
        if (rs) begin
            m_r = 0; m_ej = 0; m_cnt = 0;
        end else if (e) begin
            case (o)
                3'd1: begin m_ej = m_r >> (W - S); m_r = ((m_r << S) | si) & wmask; shifted = 1; end
                3'd2: begin m_ej = m_r & smask; m_r = (m_r >> S) | (si << (W - S)); shifted = 1; end
                3'd3: begin
                    m_ej = m_r & smask;
                    sr = W'(m_r);
                    sr = sr >>> S;
                    m_r = int'(W'(sr)) & wmask;
                    shifted = 1;
                end
                3'd4: begin m_r = ld & wmask; m_cnt = 0; end
                3'd5: if (ROT) begin
                    m_ej = m_r >> (W - S);
                    m_r = ((m_r << S) | (m_r >> (W - S))) & wmask;
                    shifted = 1;
                end
                3'd6: if (ROT) begin
                    m_ej = m_r & smask;
                    m_r = ((m_r >> S) | ((m_r & smask) << (W - S))) & wmask;
                    shifted = 1;
                end
                3'd7: begin m_r = 0; m_ej = 0; m_cnt = 0; end
                default: ;
            endcase
            if (shifted && m_cnt < N) m_cnt++;
        end
    endtask

    initial begin
        // Reset with LOAD pending must be discarded.
        vecs.push_back(mk(1, 1, 3'd4, 0, 8'hFF, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3'd4, 0, 8'hFF, 8'h00, 0, 0, 0));
        // Serialise 8'hA5 MSB first, then a 9th shift at saturation.
        vecs.push_back(mk(0, 1, 3'd4, 0, 8'hA5, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h4A, 1, 1, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h94, 0, 2, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h28, 1, 3, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h50, 0, 4, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'hA0, 0, 5, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h40, 1, 6, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h80, 0, 7, 0));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h00, 1, 8, 1));
        vecs.push_back(mk(0, 1, 3'd1, 0, 8'h00, 8'h00, 0, 8, 1));
        // LOAD while done=1 clears count and done.
        vecs.push_back(mk(0, 1, 3'd4, 0, 8'h81, 8'h81, 0, 0, 0));
        // Rotates (or HOLD when rotate is not built).
        vecs.push_back(mk(0, 1, 3'd5, 0, 8'h00, ROT ? 8'h03 : 8'h81, ROT, ROT ? 1 : 0, 0));
        vecs.push_back(mk(0, 1, 3'd6, 0, 8'h00, 8'h81, ROT, ROT ? 2 : 0, 0));
        // en=0 freezes everything, then CLEAR.
        vecs.push_back(mk(0, 1, 3'd4, 0, 8'h3C, 8'h3C, ROT, 0, 0));
        vecs.push_back(mk(0, 0, 3'd1, 1, 8'h00, 8'h3C, ROT, 0, 0));
        vecs.push_back(mk(0, 0, 3'd1, 1, 8'h00, 8'h3C, ROT, 0, 0));
        vecs.push_back(mk(0, 0, 3'd1, 1, 8'h00, 8'h3C, ROT, 0, 0));
        vecs.push_back(mk(0, 1, 3'd7, 1, 8'hFF, 8'h00, 0, 0, 0));
        // Mid-serialisation reset with SHL pending.
        vecs.push_back(mk(0, 1, 3'd4, 0, 8'h5A, 8'h5A, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 1, 8'h00, 8'hB5, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3'd1, 1, 8'h00, 8'h6B, 1, 2, 0));
        vecs.push_back(mk(0, 1, 3'd1, 1, 8'h00, 8'hD7, 0, 3, 0));
        vecs.push_back(mk(0, 1, 3'd1, 1, 8'h00, 8'hAF, 1, 4, 0));
        vecs.push_back(mk(1, 1, 3'd1, 1, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd0, 1, 8'hFF, 8'h00, 0, 0, 0));
        // SHR and ASR with STEP=1.
        vecs.push_back(mk(0, 1, 3'd4, 0, 8'h96, 8'h96, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'd3, 0, 8'h00, 8'hCB, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3'd3, 0, 8'h00, 8'hE5, 1, 2, 0));
        vecs.push_back(mk(0, 1, 3'd2, 0, 8'h00, 8'h72, 1, 3, 0));
        vecs.push_back(mk(0, 1, 3'd2, 1, 8'h00, 8'hB9, 0, 4, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc1(vecs[i].rs, vecs[i].e, vecs[i].o, vecs[i].si, vecs[i].ld);
            check($sformatf("vec%0d.r", i),    32'(shift_out), 32'(vecs[i].x_r));
            check($sformatf("vec%0d.ej", i),   32'(eject), 32'(vecs[i].x_ej));
            check($sformatf("vec%0d.cnt", i),  32'(count), 32'(vecs[i].x_cnt));
            check($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].x_done));
        end

        // STEP=2 instance: ASR/SHR then run to done.
        cyc2(1, 0, 3'd0, 2'b00, 8'h00);
        check2("s2_reset", 8'h00, 2'b00, 0, 0);
        cyc2(0, 1, 3'd4, 2'b00, 8'h80);
        check2("s2_load", 8'h80, 2'b00, 0, 0);
        cyc2(0, 1, 3'd3, 2'b11, 8'h00);
        check2("s2_asr", 8'hE0, 2'b00, 1, 0);
        cyc2(0, 1, 3'd2, 2'b01, 8'h00);
        check2("s2_shr", 8'h78, 2'b00, 2, 0);
        cyc2(0, 1, 3'd2, 2'b00, 8'h00);
        check2("s2_shr2", 8'h1E, 2'b00, 3, 0);
        cyc2(0, 1, 3'd2, 2'b00, 8'h00);
        check2("s2_done", 8'h07, 2'b10, 4, 1);
        cyc2(0, 1, 3'd1, 2'b10, 8'h00);
        check2("s2_sat", 8'h1E, 2'b00, 4, 1);
        cyc2(0, 1, 3'd4, 2'b00, 8'hC3);
        check2("s2_reload", 8'hC3, 2'b00, 0, 0);

        // Random run on the STEP=1 instance against the model.
        cyc1(1, 0, 3'd0, 0, 8'h00);
        m_r = 0; m_ej = 0; m_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            logic       rs, e, si;
            logic [2:0] o;
            logic [7:0] ld;
            rs = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 7) != 0);
            o  = 3'($urandom_range(0, 7));
            if (o == 3'd4 && $urandom_range(0, 2) != 0) o = 3'd1;
            if (o == 3'd7 && $urandom_range(0, 2) != 0) o = 3'd2;
            si = 1'($urandom);
            ld = 8'($urandom);
            cyc1(rs, e, o, si, ld);
            model_step(rs, e, o, int'(si), int'(ld));
            check($sformatf("rnd%0d.r", i),    32'(shift_out), 32'(m_r));
            check($sformatf("rnd%0d.ej", i),   32'(eject), 32'(m_ej));
            check($sformatf("rnd%0d.cnt", i),  32'(count), 32'(m_cnt));
            check($sformatf("rnd%0d.done", i), 32'(done), 32'(m_cnt == N));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
